// File: rtl/hazard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_pkg : shared types for the RV32 hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_fwd_sel : EX operand bypass select, M stage wins over W stage
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_reg_write_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_w,
  output fwd_sel_e          o_sel
);

  // x0 is hardwired to zero, so it is never a bypass source
  always_comb begin
    o_sel = FWD_RF;
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_sel = FWD_M;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_sel = FWD_W;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_mc : forwarding, load-use/RAW stalls, branch flush, mul/div stall
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int MC_MODE  = 0,
  parameter int MC_LAT   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UseRs1D,
  input  logic              UseRs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic              McDoneE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy
);

  localparam int CNT_MAX = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 1);

  mc_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ld_cnt, w_ld_cnt_nxt;
  logic [CNT_W-1:0] r_mc_cnt, w_mc_cnt_nxt;
  fwd_sel_e         w_fwd_a, w_fwd_b;

  logic w_hit_e, w_hit_m, w_hit_w;
  logic w_lu_hazard, w_raw, w_mc_exit, w_mc_stall;
  logic w_stall_f, w_stall_d, w_stall_e, w_flush_d, w_flush_e, w_flush_m;

  // A used D source that matches a writing, non-x0 destination further down
  assign w_hit_e = RegWriteE && (RdE != '0) &&
                   ((UseRs1D && (Rs1D == RdE)) || (UseRs2D && (Rs2D == RdE)));
  assign w_hit_m = RegWriteM && (RdM != '0) &&
                   ((UseRs1D && (Rs1D == RdM)) || (UseRs2D && (Rs2D == RdM)));
  assign w_hit_w = RegWriteW && (RdW != '0) &&
                   ((UseRs1D && (Rs1D == RdW)) || (UseRs2D && (Rs2D == RdW)));

  assign w_lu_hazard = (ResultSrcE == RESULT_LOAD) && w_hit_e;
  assign w_raw       = (FWD_EN == 0) && (w_hit_e || w_hit_m || w_hit_w);

  generate
    if (FWD_EN != 0) begin : g_fwd
      hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_rs_e        (Rs1E),
        .i_rd_m        (RdM),
        .i_reg_write_m (RegWriteM),
        .i_rd_w        (RdW),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_a)
      );
      hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_rs_e        (Rs2E),
        .i_rd_m        (RdM),
        .i_reg_write_m (RegWriteM),
        .i_rd_w        (RdW),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_b)
      );
    end else begin : g_no_fwd
      assign w_fwd_a = FWD_RF;
      assign w_fwd_b = FWD_RF;
    end
  endgenerate

  assign w_mc_exit  = (MC_MODE != 0) ? McDoneE : (r_mc_cnt == '0);
  // The start cycle already holds E; the exit cycle lets the op advance to M
  assign w_mc_stall = (r_state == MC_IDLE) ? McStartE : !w_mc_exit;

  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_ld_cnt_nxt = r_ld_cnt;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;

    case (r_state)
      MC_IDLE: begin
        if (McStartE) begin
          w_state_nxt  = MC_BUSY;
          w_mc_cnt_nxt = MC_INIT;
        end
      end
      MC_BUSY: begin
        if (w_mc_exit) begin
          w_state_nxt  = MC_IDLE;
          w_mc_cnt_nxt = '0;
        end else if (r_mc_cnt != '0) begin
          w_mc_cnt_nxt = r_mc_cnt - 1'b1;
        end
      end
      default: w_state_nxt = MC_IDLE;
    endcase

    if (w_mc_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
    end else if ((r_state == MC_IDLE) && PCSrcE) begin
      // Redirect discards the stalled instruction, so pending load stall goes too
      w_flush_d    = 1'b1;
      w_flush_e    = 1'b1;
      w_ld_cnt_nxt = '0;
    end else begin
      if (r_ld_cnt != '0) begin
        w_ld_cnt_nxt = r_ld_cnt - 1'b1;
      end else if (w_lu_hazard) begin
        w_ld_cnt_nxt = LD_INIT;
      end
      if (w_lu_hazard || (r_ld_cnt != '0) || w_raw) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MC_IDLE;
      r_ld_cnt <= '0;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_cnt <= w_ld_cnt_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // Every output is forced low for as long as reset is held
  assign StallF    = rst_n & w_stall_f;
  assign StallD    = rst_n & w_stall_d;
  assign StallE    = rst_n & w_stall_e;
  assign FlushD    = rst_n & w_flush_d;
  assign FlushE    = rst_n & w_flush_e;
  assign FlushM    = rst_n & w_flush_m;
  assign McBusy    = rst_n & w_mc_stall;
  assign ForwardAE = rst_n ? w_fwd_a : FWD_RF;
  assign ForwardBE = rst_n ? w_fwd_b : FWD_RF;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_mc : directed bench over three hazard_ctrl_mc configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_mc;

  // Control vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy}
  localparam logic [6:0] IDLE_V = 7'b0000000;
  localparam logic [6:0] LU_V   = 7'b1100100;
  localparam logic [6:0] MC_V   = 7'b1110011;
  localparam logic [6:0] BR_V   = 7'b0001100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       UseRs1D, UseRs2D, RegWriteE, PCSrcE, McDoneE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       mc_start [3];

  logic       stf [3], std [3], ste [3], fld [3], fle [3], flm [3], busy [3];
  logic [1:0] fa [3], fb [3];
  logic [6:0] ctl [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  for (genvar g = 0; g < 3; g++) begin : g_ctl
    assign ctl[g] = {stf[g], std[g], ste[g], fld[g], fle[g], flm[g], busy[g]};
  end

  // a: defaults; b: LOAD_LAT=3 with McDoneE handshake; c: no forwarding
  hazard_ctrl_mc #(.REG_AW(5), .FWD_EN(1), .LOAD_LAT(1), .MC_MODE(0), .MC_LAT(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(mc_start[0]), .McDoneE(McDoneE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .StallF(stf[0]), .StallD(std[0]), .StallE(ste[0]),
    .FlushD(fld[0]), .FlushE(fle[0]), .FlushM(flm[0]), .ForwardAE(fa[0]), .ForwardBE(fb[0]),
    .McBusy(busy[0]));

  hazard_ctrl_mc #(.REG_AW(5), .FWD_EN(1), .LOAD_LAT(3), .MC_MODE(1), .MC_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(mc_start[1]), .McDoneE(McDoneE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .StallF(stf[1]), .StallD(std[1]), .StallE(ste[1]),
    .FlushD(fld[1]), .FlushE(fle[1]), .FlushM(flm[1]), .ForwardAE(fa[1]), .ForwardBE(fb[1]),
    .McBusy(busy[1]));

  hazard_ctrl_mc #(.REG_AW(5), .FWD_EN(0), .LOAD_LAT(1), .MC_MODE(0), .MC_LAT(32)) dut_c (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(mc_start[2]), .McDoneE(McDoneE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .StallF(stf[2]), .StallD(std[2]), .StallE(ste[2]),
    .FlushD(fld[2]), .FlushE(fle[2]), .FlushM(flm[2]), .ForwardAE(fa[2]), .ForwardBE(fb[2]),
    .McBusy(busy[2]));

  // A multi-cycle start can never share the single E slot with a hazardous load
  wire lu_now = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                ((UseRs1D && (Rs1D == RdE)) || (UseRs2D && (Rs2D == RdE)));
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!((mc_start[0] || mc_start[1] || mc_start[2]) && lu_now))
        else $error("McStartE coincided with a load-use hazard");
    end
  end

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    UseRs1D = 1'b0; UseRs2D = 1'b0; RegWriteE = 1'b0; PCSrcE = 1'b0; McDoneE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    mc_start[0] = 1'b0; mc_start[1] = 1'b0; mc_start[2] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    PCSrcE = 1'b1; RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; mc_start[0] = 1'b1;
    Rs1D = 5'd5; UseRs1D = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ctl[i] !== IDLE_V) $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, ctl[i], IDLE_V);
      else pass_cnt++;
    end
    total_cnt++;
    if (fa[0] !== 2'b00) $display("FAIL reset_fwd_a got=%b exp=00", fa[0]);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL reset_release got=%b exp=%b", ctl[0], IDLE_V);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    next_cycle();
    clear_inputs();
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd7;
    #1;
    total_cnt++;
    if (fa[0] !== 2'b10) $display("FAIL fwd_m_prio got=%b exp=10", fa[0]); else pass_cnt++;
    total_cnt++;
    if (fb[0] !== 2'b00) $display("FAIL fwd_b_nomatch got=%b exp=00", fb[0]); else pass_cnt++;
    total_cnt++;
    if (fa[2] !== 2'b00) $display("FAIL fwd_disabled got=%b exp=00", fa[2]); else pass_cnt++;
    RdM = 5'd0; #1;
    total_cnt++;
    if (fa[0] !== 2'b01) $display("FAIL fwd_rdm_x0 got=%b exp=01", fa[0]); else pass_cnt++;
    RdM = 5'd5; RegWriteM = 1'b0; #1;
    total_cnt++;
    if (fa[0] !== 2'b01) $display("FAIL fwd_m_nowrite got=%b exp=01", fa[0]); else pass_cnt++;
    RdW = 5'd0; #1;
    total_cnt++;
    if (fa[0] !== 2'b00) $display("FAIL fwd_none got=%b exp=00", fa[0]); else pass_cnt++;
    Rs2E = 5'd7; RdW = 5'd7; RegWriteW = 1'b1; #1;
    total_cnt++;
    if (fb[0] !== 2'b01) $display("FAIL fwd_b_w got=%b exp=01", fb[0]); else pass_cnt++;
    Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; #1;
    total_cnt++;
    if (fa[0] !== 2'b00) $display("FAIL fwd_x0_src got=%b exp=00", fa[0]); else pass_cnt++;
  endtask

  task automatic test_load_use();
    logic [6:0] exp_b [4];
    exp_b[0] = LU_V; exp_b[1] = LU_V; exp_b[2] = LU_V; exp_b[3] = IDLE_V;
    next_cycle();
    clear_inputs();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; UseRs1D = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== LU_V) $display("FAIL lu_a_c0 got=%b exp=%b", ctl[0], LU_V); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        next_cycle();
        ResultSrcE = 2'b00; RegWriteE = 1'b0; RdE = 5'd0;
        #1;
      end
      if (k == 1) begin
        total_cnt++;
        if (ctl[0] !== IDLE_V) $display("FAIL lu_a_release got=%b exp=%b", ctl[0], IDLE_V);
        else pass_cnt++;
      end
      total_cnt++;
      if (ctl[1] !== exp_b[k]) $display("FAIL lu_b_c%0d got=%b exp=%b", k, ctl[1], exp_b[k]);
      else pass_cnt++;
    end
    next_cycle();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; UseRs1D = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL lu_x0 got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
    RdE = 5'd3; Rs1D = 5'd3; UseRs1D = 1'b0;
    #1;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL lu_unused got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
    Rs2D = 5'd3; UseRs2D = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== LU_V) $display("FAIL lu_rs2 got=%b exp=%b", ctl[0], LU_V); else pass_cnt++;
    next_cycle(); clear_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_mc_fixed();
    logic [6:0] exp_v;
    next_cycle();
    clear_inputs();
    mc_start[0] = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== MC_V) $display("FAIL mc0_entry got=%b exp=%b", ctl[0], MC_V); else pass_cnt++;
    for (int k = 1; k <= 34; k++) begin
      next_cycle();
      mc_start[0] = 1'b0;
      PCSrcE = (k == 10);
      #1;
      exp_v = (k <= 31) ? MC_V : IDLE_V;
      total_cnt++;
      if (ctl[0] !== exp_v) $display("FAIL mc0_cyc%0d got=%b exp=%b", k, ctl[0], exp_v);
      else pass_cnt++;
    end
    PCSrcE = 1'b0;
  endtask

  task automatic test_mc_done();
    logic [6:0] exp_v;
    next_cycle();
    clear_inputs();
    McDoneE = 1'b1;
    #1;
    total_cnt++;
    if (ctl[1] !== IDLE_V) $display("FAIL mc1_done_idle got=%b exp=%b", ctl[1], IDLE_V); else pass_cnt++;
    next_cycle();
    McDoneE = 1'b0;
    #1;
    total_cnt++;
    if (ctl[1] !== IDLE_V) $display("FAIL mc1_done_noenter got=%b exp=%b", ctl[1], IDLE_V); else pass_cnt++;
    next_cycle();
    mc_start[1] = 1'b1;
    #1;
    total_cnt++;
    if (ctl[1] !== MC_V) $display("FAIL mc1_entry got=%b exp=%b", ctl[1], MC_V); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      mc_start[1] = 1'b0;
      McDoneE = (k >= 6);
      #1;
      exp_v = (k <= 5) ? MC_V : IDLE_V;
      total_cnt++;
      if (ctl[1] !== exp_v) $display("FAIL mc1_cyc%0d got=%b exp=%b", k, ctl[1], exp_v);
      else pass_cnt++;
    end
    McDoneE = 1'b0;
  endtask

  task automatic test_branch_flush();
    next_cycle();
    clear_inputs();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; UseRs1D = 1'b1;
    #1;
    total_cnt++;
    if (ctl[1] !== LU_V) $display("FAIL br_lu_start got=%b exp=%b", ctl[1], LU_V); else pass_cnt++;
    next_cycle();
    ResultSrcE = 2'b00; RegWriteE = 1'b0; RdE = 5'd0; PCSrcE = 1'b1;
    #1;
    total_cnt++;
    if (ctl[1] !== BR_V) $display("FAIL br_over_lu got=%b exp=%b", ctl[1], BR_V); else pass_cnt++;
    next_cycle();
    PCSrcE = 1'b0;
    #1;
    total_cnt++;
    if (ctl[1] !== IDLE_V) $display("FAIL br_cnt_clear got=%b exp=%b", ctl[1], IDLE_V); else pass_cnt++;
    next_cycle();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd3; PCSrcE = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== BR_V) $display("FAIL br_same_a got=%b exp=%b", ctl[0], BR_V); else pass_cnt++;
    total_cnt++;
    if (ctl[1] !== BR_V) $display("FAIL br_same_b got=%b exp=%b", ctl[1], BR_V); else pass_cnt++;
    next_cycle();
    clear_inputs();
    #1;
    total_cnt++;
    if (ctl[1] !== IDLE_V) $display("FAIL br_same_noload got=%b exp=%b", ctl[1], IDLE_V); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    clear_inputs();
    mc_start[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      mc_start[0] = 1'b0;
    end
    #1;
    total_cnt++;
    if (ctl[0] !== MC_V) $display("FAIL rst_mid_busy got=%b exp=%b", ctl[0], MC_V); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL rst_mid_async got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
    next_cycle();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL rst_mid_rel0 got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL rst_mid_rel1 got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
  endtask

  task automatic test_raw_nofwd();
    next_cycle();
    clear_inputs();
    Rs1D = 5'd4; UseRs1D = 1'b1; RdM = 5'd4; RegWriteM = 1'b1;
    #1;
    total_cnt++;
    if (ctl[2] !== LU_V) $display("FAIL raw_m got=%b exp=%b", ctl[2], LU_V); else pass_cnt++;
    total_cnt++;
    if (ctl[0] !== IDLE_V) $display("FAIL raw_fwd_nostall got=%b exp=%b", ctl[0], IDLE_V); else pass_cnt++;
    RegWriteM = 1'b0; Rs2D = 5'd6; RdW = 5'd6; RegWriteW = 1'b1;
    #1;
    total_cnt++;
    if (ctl[2] !== IDLE_V) $display("FAIL raw_unused got=%b exp=%b", ctl[2], IDLE_V); else pass_cnt++;
    UseRs2D = 1'b1;
    #1;
    total_cnt++;
    if (ctl[2] !== LU_V) $display("FAIL raw_w got=%b exp=%b", ctl[2], LU_V); else pass_cnt++;
    Rs2D = 5'd0; RdW = 5'd0;
    #1;
    total_cnt++;
    if (ctl[2] !== IDLE_V) $display("FAIL raw_x0 got=%b exp=%b", ctl[2], IDLE_V); else pass_cnt++;
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mc_fixed();
    test_mc_done();
    test_branch_flush();
    test_reset_mid();
    test_raw_nofwd();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
